// File: rtl/pq_timer_dispatch.sv
// Timer-gated dispatcher: pops the minimum {key,value} from systolic_pq, holds it
// until the free-running modular timer reaches the key, then presents it downstream.
module pq_timer_dispatch #(
    parameter int KW = 8,
    parameter int VW = 4,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             pq_ovalid,
    input  logic [KW+VW-1:0] pq_odata,
    output logic             pq_ordy,
    output logic             evalid,
    output logic [KW-1:0]    ekey,
    output logic [VW-1:0]    evalue,
    output logic             elate,
    input  logic             erdy,
    output logic [KW-1:0]    now,
    output logic [CW-1:0]    disp_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] hkey;
    logic [VW-1:0] hval;
    logic [KW-1:0] diff;
    logic          due;
    logic          take;
    logic          done;

    // A key is due when (now - key) lands in the lower half of the modular circle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        take       = 1'b0;
        done       = 1'b0;
        diff       = now - hkey;
        due        = ~diff[KW-1];
        unique case (state)
            IDLE: begin
                if (pq_ovalid && pq_ordy) begin
                    take       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (due) state_next = PRESENT;
            end
            PRESENT: begin
                if (erdy) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      now <= '0;
        else if (tick) now <= now + KW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq_ordy    <= 1'b0;
            hkey       <= '0;
            hval       <= '0;
            evalid     <= 1'b0;
            ekey       <= '0;
            evalue     <= '0;
            elate      <= 1'b0;
            disp_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        hkey    <= pq_odata[KW+VW-1:VW];
                        hval    <= pq_odata[VW-1:0];
                        pq_ordy <= 1'b0;
                    end else begin
                        pq_ordy <= 1'b1;
                    end
                end
                WAIT: begin
                    pq_ordy <= 1'b0;
                    if (due) begin
                        ekey   <= hkey;
                        evalue <= hval;
                        elate  <= (diff != '0);
                        evalid <= 1'b1;
                    end
                end
                PRESENT: begin
                    // Re-arming the pop here lets a queued entry transfer on the first IDLE cycle.
                    if (done) begin
                        evalid     <= 1'b0;
                        elate      <= 1'b0;
                        disp_count <= disp_count + CW'(1);
                        pq_ordy    <= 1'b1;
                    end
                end
                default: pq_ordy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_timer_dispatch.sv
// Directed bench for pq_timer_dispatch: drives the pop interface directly and
// checks dispatch timing, lateness, wrap handling, backpressure and reset.
module tb_pq_timer_dispatch;

    localparam int KW = 8;
    localparam int VW = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick = 1'b0;
    logic             pq_ovalid = 1'b0;
    logic [KW+VW-1:0] pq_odata = '0;
    logic             pq_ordy;
    logic             evalid;
    logic [KW-1:0]    ekey;
    logic [VW-1:0]    evalue;
    logic             elate;
    logic             erdy = 1'b0;
    logic [KW-1:0]    now;
    logic [CW-1:0]    disp_count;

    int vec_count = 0;
    int err_count = 0;

    pq_timer_dispatch #(.KW(KW), .VW(VW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .pq_ovalid  (pq_ovalid),
        .pq_odata   (pq_odata),
        .pq_ordy    (pq_ordy),
        .evalid     (evalid),
        .ekey       (ekey),
        .evalue     (evalue),
        .elate      (elate),
        .erdy       (erdy),
        .now        (now),
        .disp_count (disp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic run_now(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        pq_ovalid = 1'b0;
        erdy      = 1'b0;
        tick      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pop(input logic [11:0] data);
        pq_odata  = data;
        pq_ovalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pq_ordy) begin
                @(negedge clk);
                pq_ovalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        pq_ovalid = 1'b0;
        check("pop_timeout", pq_ordy, 1);
    endtask

    task automatic wait_ev(input int max);
        for (int i = 0; i < max; i++) begin
            if (evalid) return;
            @(negedge clk);
        end
        check("ev_timeout", evalid, 1);
    endtask

    task automatic handshake();
        erdy = 1'b1;
        @(negedge clk);
        erdy = 1'b0;
    endtask

    logic [11:0] ent [3];
    bit          gone [3];
    logic [7:0]  ek [3];
    logic [3:0]  evl [3];
    logic        el [3];
    int          et [3];
    int          nev;
    int          mi;
    bit          saw_wrap;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ordy", pq_ordy, 0);
        check("rst_evalid", evalid, 0);
        check("rst_ekey", ekey, 0);
        check("rst_evalue", evalue, 0);
        check("rst_elate", elate, 0);
        check("rst_now", now, 0);
        check("rst_count", disp_count, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ordy_after_release", pq_ordy, 1);

        // Late key with tick=0, then backpressure on the presented event
        run_now(8'h50);
        check("late_now", now, 8'h50);
        pop(12'h111);
        check("late_ordy_capt", pq_ordy, 0);
        check("late_evalid_capt", evalid, 0);
        @(negedge clk);
        check("late_evalid", evalid, 1);
        check("late_ekey", ekey, 8'h11);
        check("late_evalue", evalue, 4'h1);
        check("late_elate", elate, 1);
        pq_ovalid = 1'b1;
        pq_odata  = 12'hEEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_evalid", evalid, 1);
            check("bp_ekey", ekey, 8'h11);
            check("bp_evalue", evalue, 4'h1);
            check("bp_ordy", pq_ordy, 0);
            check("bp_count", disp_count, 0);
        end
        pq_ovalid = 1'b0;
        handshake();
        check("hs_evalid", evalid, 0);
        check("hs_elate", elate, 0);
        check("hs_count", disp_count, 1);
        check("hs_ordy", pq_ordy, 1);
        pop(12'h502);
        @(negedge clk);
        check("d0_evalid", evalid, 1);
        check("d0_ekey", ekey, 8'h50);
        check("d0_evalue", evalue, 4'h2);
        check("d0_elate", elate, 0);
        handshake();
        check("d0_count", disp_count, 2);

        // Future key while ticking
        do_reset();
        run_now(16);
        check("fut_now", now, 8'h10);
        tick = 1'b1;
        pop(12'h304);
        for (int i = 0; i < 100 && !evalid; i++) begin
            if (now == 8'h30) check("fut_early", evalid, 0);
            @(negedge clk);
        end
        check("fut_evalid", evalid, 1);
        check("fut_now_at_ev", now, 8'h31);
        check("fut_ekey", ekey, 8'h30);
        check("fut_evalue", evalue, 4'h4);
        check("fut_elate", elate, 0);
        tick = 1'b0;
        handshake();

        // Key held across the timer wrap
        do_reset();
        run_now(248);
        check("wrap_now", now, 8'hF8);
        tick     = 1'b1;
        saw_wrap = 1'b0;
        pop(12'h055);
        for (int i = 0; i < 100 && !evalid; i++) begin
            if (now == 8'hFF) saw_wrap = 1'b1;
            @(negedge clk);
        end
        check("wrap_passed_ff", saw_wrap, 1);
        check("wrap_evalid", evalid, 1);
        check("wrap_now_at_ev", now, 8'h06);
        check("wrap_ekey", ekey, 8'h05);
        check("wrap_evalue", evalue, 4'h5);
        check("wrap_elate", elate, 0);
        tick = 1'b0;
        handshake();

        // d = 0x80 is treated as future and never dispatches
        do_reset();
        run_now(248);
        pop(12'h784);
        repeat (20) @(negedge clk);
        check("half_evalid", evalid, 0);
        check("half_ordy", pq_ordy, 0);
        check("half_now", now, 8'hF8);

        // d = 0x7F is still in the past
        do_reset();
        run_now(247);
        pop(12'h784);
        @(negedge clk);
        check("d7f_evalid", evalid, 1);
        check("d7f_elate", elate, 1);
        handshake();

        // Back-to-back from a sorted source
        do_reset();
        run_now(32);
        ent[0] = 12'h111;
        ent[1] = 12'h202;
        ent[2] = 12'h143;
        for (int j = 0; j < 3; j++) gone[j] = 1'b0;
        nev  = 0;
        erdy = 1'b1;
        for (int cyc = 0; cyc < 60 && nev < 3; cyc++) begin
            if (evalid) begin
                ek[nev]  = ekey;
                evl[nev] = evalue;
                el[nev]  = elate;
                et[nev]  = cyc;
                nev++;
            end
            mi = -1;
            for (int j = 0; j < 3; j++)
                if (!gone[j] && (mi < 0 || ent[j] < ent[mi])) mi = j;
            if (mi >= 0) begin
                pq_ovalid = 1'b1;
                pq_odata  = ent[mi];
                if (pq_ordy) gone[mi] = 1'b1;
            end else begin
                pq_ovalid = 1'b0;
            end
            @(negedge clk);
        end
        pq_ovalid = 1'b0;
        erdy      = 1'b0;
        check("b2b_events", nev, 3);
        check("b2b_key0", ek[0], 8'h11);
        check("b2b_key1", ek[1], 8'h14);
        check("b2b_key2", ek[2], 8'h20);
        check("b2b_val0", evl[0], 4'h1);
        check("b2b_val1", evl[1], 4'h3);
        check("b2b_val2", evl[2], 4'h2);
        check("b2b_late0", el[0], 1);
        check("b2b_late1", el[1], 1);
        check("b2b_late2", el[2], 0);
        check("b2b_gap01", et[1] - et[0], 3);
        check("b2b_gap12", et[2] - et[1], 3);
        check("b2b_count", disp_count, 3);

        // Asynchronous reset while an event is presented
        pop(12'h0A1);
        wait_ev(10);
        check("mid_evalid_pre", evalid, 1);
        check("mid_count_pre", disp_count, 3);
        #2 rst = 1'b0;
        #1;
        check("mid_evalid", evalid, 0);
        check("mid_now", now, 0);
        check("mid_count", disp_count, 0);
        check("mid_ordy", pq_ordy, 0);
        check("mid_ekey", ekey, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ordy_rel", pq_ordy, 1);
        check("mid_evalid_rel", evalid, 0);
        pop(12'h003);
        @(negedge clk);
        check("post_evalid", evalid, 1);
        check("post_ekey", ekey, 8'h00);
        check("post_evalue", evalue, 4'h3);
        check("post_elate", elate, 0);
        handshake();
        check("post_count", disp_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
